// File: rtl/checkpoint_table_if.sv
// Dispatch/ROB-facing bus of the map-table checkpoint store.
// master = dispatch stage + ROB, slave = checkpoint_table.
interface checkpoint_table_if #(
    parameter int unsigned CHECKPOINT_COLUMNS = 4,
    parameter int unsigned ARCH_REGS          = 32,
    parameter int unsigned PHYS_TAG_W         = 6,
    parameter int unsigned ROB_INDEX_W        = 4
);
    localparam int unsigned COL_W = $clog2(CHECKPOINT_COLUMNS);
    localparam int unsigned MAP_W = ARCH_REGS * PHYS_TAG_W;

    logic                   save_valid;
    logic [ROB_INDEX_W-1:0] save_ROB_index;
    logic [MAP_W-1:0]       save_map_table;
    logic                   save_ready;
    logic [COL_W-1:0]       save_column;

    logic                   restore_checkpoint_valid;
    logic                   restore_checkpoint_speculate_failed;
    logic [ROB_INDEX_W-1:0] restore_checkpoint_ROB_index;
    logic [COL_W-1:0]       restore_checkpoint_safe_column;
    logic                   restore_checkpoint_success;

    logic                   map_restore_valid;
    logic [MAP_W-1:0]       map_restore_table;

    logic                   full;
    logic                   empty;
    logic [COL_W:0]         count;
    logic                   DUT_error;
    logic [15:0]            stat_restores;
    logic [15:0]            stat_frees;

    modport master (
        output save_valid, save_ROB_index, save_map_table,
        output restore_checkpoint_valid, restore_checkpoint_speculate_failed,
        output restore_checkpoint_ROB_index, restore_checkpoint_safe_column,
        input  save_ready, save_column, restore_checkpoint_success,
        input  map_restore_valid, map_restore_table,
        input  full, empty, count, DUT_error, stat_restores, stat_frees
    );

    modport slave (
        input  save_valid, save_ROB_index, save_map_table,
        input  restore_checkpoint_valid, restore_checkpoint_speculate_failed,
        input  restore_checkpoint_ROB_index, restore_checkpoint_safe_column,
        output save_ready, save_column, restore_checkpoint_success,
        output map_restore_valid, map_restore_table,
        output full, empty, count, DUT_error, stat_restores, stat_frees
    );
endinterface

// File: rtl/checkpoint_table.sv
// Circular store of speculative map-table snapshots, one column per in-flight branch.
// Optional CHECKPOINT_STATS_EN builds saturating restore/free perf counters.
module checkpoint_table #(
    parameter int unsigned CHECKPOINT_COLUMNS = 4,
    parameter int unsigned ARCH_REGS          = 32,
    parameter int unsigned PHYS_TAG_W         = 6,
    parameter int unsigned ROB_INDEX_W        = 4
) (
    input logic               CLK,
    input logic               nRST,
    checkpoint_table_if.slave bus
);
    localparam int unsigned COL_W = $clog2(CHECKPOINT_COLUMNS);
    localparam int unsigned CNT_W = COL_W + 1;
    localparam int unsigned MAP_W = ARCH_REGS * PHYS_TAG_W;

    logic [CHECKPOINT_COLUMNS-1:0] valid_q, resolved_q;
    logic [CHECKPOINT_COLUMNS-1:0] valid_nx, resolved_nx, kill_c;
    logic [ROB_INDEX_W-1:0]        rob_q  [CHECKPOINT_COLUMNS];
    logic [MAP_W-1:0]              snap_q [CHECKPOINT_COLUMNS];
    logic [COL_W-1:0]              head_q, tail_q, safe_off_c;
    logic [CNT_W-1:0]              count_q;
    logic                          success_q, map_valid_q, error_q;
    logic [MAP_W-1:0]              map_table_q;

    logic full_c, save_ready_c, save_fire_c, match_c, mispredict_c, resolve_c, drain_c;
    logic [COL_W-1:0] safe_col;

    assign safe_col     = bus.restore_checkpoint_safe_column;
    assign full_c       = (count_q == CNT_W'(CHECKPOINT_COLUMNS));
    assign save_ready_c = !full_c && !bus.restore_checkpoint_valid;
    assign save_fire_c  = bus.save_valid && save_ready_c;
    assign match_c      = bus.restore_checkpoint_valid && valid_q[safe_col] && !resolved_q[safe_col]
                          && (rob_q[safe_col] == bus.restore_checkpoint_ROB_index);
    assign mispredict_c = match_c && bus.restore_checkpoint_speculate_failed;
    assign resolve_c    = match_c && !bus.restore_checkpoint_speculate_failed;
    assign drain_c      = !mispredict_c && valid_q[head_q] && resolved_q[head_q];
    assign safe_off_c   = COL_W'(safe_col - head_q);

    // A mispredict discards the restored column and everything younger, i.e. age offset >= its own.
    always_comb begin
        kill_c = '0;
        for (int unsigned i = 0; i < CHECKPOINT_COLUMNS; i++) begin
            kill_c[i] = (COL_W'(COL_W'(i) - head_q) >= safe_off_c);
        end
    end

    always_comb begin
        valid_nx    = valid_q;
        resolved_nx = resolved_q;
        if (mispredict_c) begin
            valid_nx    = valid_q & ~kill_c;
            resolved_nx = resolved_q & ~kill_c;
        end else begin
            if (resolve_c) begin
                resolved_nx[safe_col] = 1'b1;
            end
            if (drain_c) begin
                valid_nx[head_q]    = 1'b0;
                resolved_nx[head_q] = 1'b0;
            end
            if (save_fire_c) begin
                valid_nx[tail_q]    = 1'b1;
                resolved_nx[tail_q] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            valid_q     <= '0;
            resolved_q  <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            success_q   <= 1'b0;
            map_valid_q <= 1'b0;
            map_table_q <= '0;
            error_q     <= 1'b0;
        end else begin
            valid_q     <= valid_nx;
            resolved_q  <= resolved_nx;
            success_q   <= match_c;
            map_valid_q <= mispredict_c;
            error_q     <= bus.save_valid && !save_ready_c;
            if (mispredict_c) begin
                map_table_q <= snap_q[safe_col];
                tail_q      <= safe_col;
                count_q     <= CNT_W'(safe_off_c);
            end else begin
                if (drain_c) begin
                    head_q <= head_q + COL_W'(1);
                end
                if (save_fire_c) begin
                    tail_q <= tail_q + COL_W'(1);
                end
                count_q <= count_q + CNT_W'(save_fire_c) - CNT_W'(drain_c);
            end
        end
    end

    // Payload storage needs no reset: a column is only read while its valid bit is set.
    always_ff @(posedge CLK) begin
        if (save_fire_c) begin
            snap_q[tail_q] <= bus.save_map_table;
            rob_q[tail_q]  <= bus.save_ROB_index;
        end
    end

    assign bus.save_ready                 = save_ready_c;
    assign bus.save_column                = tail_q;
    assign bus.restore_checkpoint_success = success_q;
    assign bus.map_restore_valid          = map_valid_q;
    assign bus.map_restore_table          = map_table_q;
    assign bus.full                       = full_c;
    assign bus.empty                      = (count_q == '0);
    assign bus.count                      = count_q;
    assign bus.DUT_error                  = error_q;

`ifdef CHECKPOINT_STATS_EN
    logic [15:0] stat_restores_q, stat_frees_q;

    always_ff @(posedge CLK) begin
        if (nRST) begin
            stat_restores_q <= '0;
            stat_frees_q    <= '0;
        end else begin
            if (mispredict_c && !(&stat_restores_q)) begin
                stat_restores_q <= stat_restores_q + 16'd1;
            end
            if (drain_c && !(&stat_frees_q)) begin
                stat_frees_q <= stat_frees_q + 16'd1;
            end
        end
    end

    assign bus.stat_restores = stat_restores_q;
    assign bus.stat_frees    = stat_frees_q;
`else
    assign bus.stat_restores = 16'd0;
    assign bus.stat_frees    = 16'd0;
`endif
endmodule

// File: tb/tb_checkpoint_table.sv
// Self-checking bench for checkpoint_table: directed scenarios plus randomized traffic
// against a queue-based model of the live checkpoints (oldest first).
module tb_checkpoint_table;
    localparam int unsigned N  = 4;
    localparam int unsigned AR = 32;
    localparam int unsigned TW = 6;
    localparam int unsigned RW = 4;
    localparam int unsigned MW = AR * TW;

    logic CLK;
    logic nRST;

    checkpoint_table_if #(.CHECKPOINT_COLUMNS(N), .ARCH_REGS(AR), .PHYS_TAG_W(TW), .ROB_INDEX_W(RW)) bus ();

    checkpoint_table #(.CHECKPOINT_COLUMNS(N), .ARCH_REGS(AR), .PHYS_TAG_W(TW), .ROB_INDEX_W(RW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned    col;
        logic [RW-1:0]  rob;
        logic [MW-1:0]  snap;
        bit             res;
    } ent_t;

    ent_t          q[$];
    int unsigned   m_head;
    logic [MW-1:0] m_table;
    bit            m_succ, m_mrv, m_err;
    int unsigned   m_restores, m_frees;
    int            errors;
    int            checks;

    function automatic logic [MW-1:0] rand_map();
        logic [MW-1:0] m;
        for (int i = 0; i < MW / 32; i++) m[i*32 +: 32] = $urandom;
        return m;
    endfunction

    function automatic logic [15:0] exp_restores();
`ifdef CHECKPOINT_STATS_EN
        return 16'(m_restores);
`else
        return 16'd0;
`endif
    endfunction

    function automatic logic [15:0] exp_frees();
`ifdef CHECKPOINT_STATS_EN
        return 16'(m_frees);
`else
        return 16'd0;
`endif
    endfunction

    function automatic int unsigned m_tail();
        return (m_head + q.size()) % N;
    endfunction

    // Advance the model with the inputs currently driven, then cross one clock edge.
    task automatic tick();
        bit   ready;
        bit   drain;
        int   k;
        ent_t e;
        ready = (q.size() < N) && !bus.restore_checkpoint_valid;
        k = -1;
        if (nRST) begin
            q.delete();
            m_head = 0; m_table = '0; m_succ = 0; m_mrv = 0; m_err = 0;
            m_restores = 0; m_frees = 0;
        end else begin
            if (bus.restore_checkpoint_valid)
                foreach (q[j])
                    if (q[j].col == bus.restore_checkpoint_safe_column &&
                        q[j].rob == bus.restore_checkpoint_ROB_index && !q[j].res) k = j;
            m_succ = (k >= 0);
            m_mrv  = (k >= 0) && bus.restore_checkpoint_speculate_failed;
            m_err  = bus.save_valid && !ready;
            if (m_mrv) begin
                m_table = q[k].snap;
                while (q.size() > k) q.delete(q.size() - 1);
                if (m_restores < 65535) m_restores++;
            end else begin
                drain = (q.size() > 0) && q[0].res;
                e.col = m_tail();
                if (k >= 0) q[k].res = 1;
                if (drain) begin
                    q.delete(0);
                    m_head = (m_head + 1) % N;
                    if (m_frees < 65535) m_frees++;
                end
                if (bus.save_valid && ready) begin
                    e.rob = bus.save_ROB_index; e.snap = bus.save_map_table; e.res = 0;
                    q.push_back(e);
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic set_idle();
        bus.save_valid                          = 1'b0;
        bus.save_ROB_index                      = '0;
        bus.save_map_table                      = '0;
        bus.restore_checkpoint_valid            = 1'b0;
        bus.restore_checkpoint_speculate_failed = 1'b0;
        bus.restore_checkpoint_ROB_index        = '0;
        bus.restore_checkpoint_safe_column      = '0;
    endtask

    task automatic do_save(input logic [RW-1:0] rob, input logic [MW-1:0] tbl);
        set_idle();
        bus.save_valid = 1'b1; bus.save_ROB_index = rob; bus.save_map_table = tbl;
        tick();
        set_idle();
    endtask

    task automatic do_restore(input int unsigned col, input logic [RW-1:0] rob, input bit failed);
        set_idle();
        bus.restore_checkpoint_valid            = 1'b1;
        bus.restore_checkpoint_safe_column      = 2'(col);
        bus.restore_checkpoint_ROB_index        = rob;
        bus.restore_checkpoint_speculate_failed = failed;
        tick();
        set_idle();
    endtask

    task automatic idle_tick();
        set_idle();
        tick();
    endtask

    task automatic test_reset();
        nRST = 1'b1;
        set_idle();
        tick(); tick();
        nRST = 1'b0;
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.full); end
        checks++; if (bus.save_ready !== 1'b1) begin errors++; $display("FAIL reset_save_ready got=%b exp=1", bus.save_ready); end
        checks++; if (bus.save_column !== 2'd0) begin errors++; $display("FAIL reset_save_column got=%0d exp=0", bus.save_column); end
        checks++; if (bus.restore_checkpoint_success !== 1'b0 || bus.map_restore_valid !== 1'b0)
            begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", bus.restore_checkpoint_success, bus.map_restore_valid); end
        checks++; if (bus.map_restore_table !== '0) begin errors++; $display("FAIL reset_table got=%h exp=0", bus.map_restore_table); end
        checks++; if (bus.DUT_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", bus.DUT_error); end
        checks++; if (bus.stat_restores !== 16'd0 || bus.stat_frees !== 16'd0)
            begin errors++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", bus.stat_restores, bus.stat_frees); end
    endtask

    task automatic test_save_restore();
        logic [MW-1:0] tbl;
        tbl = rand_map();
        tbl[5*TW +: TW] = 6'd40;
        set_idle();
        bus.save_valid = 1'b1; bus.save_ROB_index = 4'd3; bus.save_map_table = tbl;
        #1;
        checks++; if (bus.save_column !== 2'd0) begin errors++; $display("FAIL sr_save_column got=%0d exp=0", bus.save_column); end
        tick();
        set_idle();
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL sr_count got=%0d exp=1", bus.count); end
        do_restore(0, 4'd3, 1'b1);
        checks++; if (bus.restore_checkpoint_success !== 1'b1) begin errors++; $display("FAIL sr_success got=%b exp=1", bus.restore_checkpoint_success); end
        checks++; if (bus.map_restore_valid !== 1'b1) begin errors++; $display("FAIL sr_map_valid got=%b exp=1", bus.map_restore_valid); end
        checks++; if (bus.map_restore_table[5*TW +: TW] !== 6'd40) begin errors++; $display("FAIL sr_entry5 got=%0d exp=40", bus.map_restore_table[5*TW +: TW]); end
        checks++; if (bus.map_restore_table !== tbl) begin errors++; $display("FAIL sr_table got=%h exp=%h", bus.map_restore_table, tbl); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL sr_empty got=%b exp=1", bus.empty); end
        idle_tick();
        checks++; if (bus.restore_checkpoint_success !== 1'b0 || bus.map_restore_valid !== 1'b0)
            begin errors++; $display("FAIL sr_pulse_end got=%b%b exp=00", bus.restore_checkpoint_success, bus.map_restore_valid); end
        checks++; if (bus.map_restore_table !== tbl) begin errors++; $display("FAIL sr_table_hold got=%h exp=%h", bus.map_restore_table, tbl); end
    endtask

    task automatic test_fill_overflow();
        int unsigned   h;
        logic [MW-1:0] tbl0;
        h = m_head;
        tbl0 = rand_map();
        do_save(4'd0, tbl0);
        for (int i = 1; i < 4; i++) do_save(4'(i), rand_map());
        checks++; if (bus.full !== 1'b1 || bus.save_ready !== 1'b0)
            begin errors++; $display("FAIL fill_full got full=%b ready=%b exp full=1 ready=0", bus.full, bus.save_ready); end
        do_save(4'd9, rand_map());
        checks++; if (bus.DUT_error !== 1'b1) begin errors++; $display("FAIL ovf_error got=%b exp=1", bus.DUT_error); end
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", bus.count); end
        idle_tick();
        checks++; if (bus.DUT_error !== 1'b0) begin errors++; $display("FAIL ovf_error_pulse got=%b exp=0", bus.DUT_error); end
        do_restore(h, 4'd0, 1'b1);
        checks++; if (bus.map_restore_table !== tbl0) begin errors++; $display("FAIL ovf_head_snapshot got=%h exp=%h", bus.map_restore_table, tbl0); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL ovf_cleanup_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_in_order_drain();
        int unsigned h;
        logic [2:0]  exp_cnt [5];
        h = m_head;
        for (int i = 0; i < 4; i++) do_save(4'(i), rand_map());
        do_restore((h + 2) % N, 4'd2, 1'b0);
        idle_tick();
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL drain_blocked got=%0d exp=4", bus.count); end
        do_restore(h, 4'd0, 1'b0);
        do_restore((h + 1) % N, 4'd1, 1'b0);
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL drain_first got=%0d exp=3", bus.count); end
        exp_cnt = '{3'd2, 3'd1, 3'd1, 3'd1, 3'd1};
        for (int i = 0; i < 3; i++) begin
            idle_tick();
            checks++; if (bus.count !== exp_cnt[i]) begin errors++; $display("FAIL drain_step%0d got=%0d exp=%0d", i, bus.count, exp_cnt[i]); end
        end
        do_restore((h + 3) % N, 4'd3, 1'b1);
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL drain_cleanup got=%0d exp=0", bus.count); end
    endtask

    task automatic test_mispredict_truncate();
        int unsigned h;
        h = m_head;
        for (int i = 0; i < 4; i++) do_save(4'(10 + i), rand_map());
        do_restore((h + 1) % N, 4'd11, 1'b1);
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL trunc_count got=%0d exp=1", bus.count); end
        checks++; if (bus.save_column !== 2'((h + 1) % N)) begin errors++; $display("FAIL trunc_tail got=%0d exp=%0d", bus.save_column, (h + 1) % N); end
        do_restore((h + 2) % N, 4'd12, 1'b0);
        checks++; if (bus.restore_checkpoint_success !== 1'b0) begin errors++; $display("FAIL trunc_dead_col got=%b exp=0", bus.restore_checkpoint_success); end
        do_save(4'd7, rand_map());
        checks++; if (bus.count !== 3'd2 || bus.save_column !== 2'((h + 2) % N))
            begin errors++; $display("FAIL trunc_resave got count=%0d col=%0d exp 2/%0d", bus.count, bus.save_column, (h + 2) % N); end
        do_restore(h, 4'd10, 1'b1);
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL trunc_cleanup got=%0d exp=0", bus.count); end
    endtask

    task automatic test_mismatch_and_collision();
        int unsigned h;
        h = m_head;
        do_save(4'd5, rand_map());
        do_restore(h, 4'd6, 1'b1);
        checks++; if (bus.restore_checkpoint_success !== 1'b0 || bus.DUT_error !== 1'b0)
            begin errors++; $display("FAIL mm_probe got succ=%b err=%b exp 0/0", bus.restore_checkpoint_success, bus.DUT_error); end
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL mm_count got=%0d exp=1", bus.count); end
        set_idle();
        bus.save_valid = 1'b1; bus.save_ROB_index = 4'd8; bus.save_map_table = rand_map();
        bus.restore_checkpoint_valid = 1'b1; bus.restore_checkpoint_safe_column = 2'(h);
        bus.restore_checkpoint_ROB_index = 4'd5;
        #1;
        checks++; if (bus.save_ready !== 1'b0) begin errors++; $display("FAIL coll_ready got=%b exp=0", bus.save_ready); end
        tick();
        set_idle();
        checks++; if (bus.restore_checkpoint_success !== 1'b1 || bus.DUT_error !== 1'b1 || bus.count !== 3'd1)
            begin errors++; $display("FAIL coll_result got succ=%b err=%b cnt=%0d exp 1/1/1", bus.restore_checkpoint_success, bus.DUT_error, bus.count); end
        idle_tick();
        checks++; if (bus.count !== 3'd0 || bus.DUT_error !== 1'b0)
            begin errors++; $display("FAIL coll_drain got cnt=%0d err=%b exp 0/0", bus.count, bus.DUT_error); end
    endtask

    task automatic test_wrap();
        int unsigned h;
        int unsigned f0;
        h = m_head;
        f0 = m_frees;
        for (int i = 0; i < 6; i++) begin
            do_save(4'(i), rand_map());
            do_restore((h + i) % N, 4'(i), 1'b0);
        end
        idle_tick();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", bus.empty); end
        checks++; if (bus.save_column !== 2'((h + 6) % N)) begin errors++; $display("FAIL wrap_tail got=%0d exp=%0d", bus.save_column, (h + 6) % N); end
`ifdef CHECKPOINT_STATS_EN
        checks++; if (bus.stat_frees !== 16'(f0 + 6)) begin errors++; $display("FAIL wrap_stat_frees got=%0d exp=%0d", bus.stat_frees, f0 + 6); end
`else
        checks++; if (bus.stat_frees !== 16'd0) begin errors++; $display("FAIL wrap_stat_frees got=%0d exp=0 (f0=%0d)", bus.stat_frees, f0); end
`endif
    endtask

    task automatic test_random();
        int k;
        bit exp_ready;
        for (int c = 0; c < 800; c++) begin
            set_idle();
            nRST = ($urandom_range(99) == 0);
            if ($urandom_range(1) == 1) begin
                bus.save_valid = 1'b1; bus.save_ROB_index = 4'($urandom); bus.save_map_table = rand_map();
            end
            if ($urandom_range(9) < 3) begin
                bus.restore_checkpoint_valid = 1'b1;
                bus.restore_checkpoint_speculate_failed = ($urandom_range(2) == 0);
                if (q.size() > 0 && $urandom_range(3) != 0) begin
                    k = $urandom_range(q.size() - 1);
                    bus.restore_checkpoint_safe_column = 2'(q[k].col);
                    bus.restore_checkpoint_ROB_index   = q[k].rob + 4'($urandom_range(7) == 0);
                end else begin
                    bus.restore_checkpoint_safe_column = 2'($urandom);
                    bus.restore_checkpoint_ROB_index   = 4'($urandom);
                end
            end
            #1;
            exp_ready = (q.size() < N) && !bus.restore_checkpoint_valid;
            checks++; if (bus.save_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, bus.save_ready, exp_ready); end
            tick();
            checks++; if (bus.count !== 3'(q.size())) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, bus.count, q.size()); end
            checks++; if (bus.full !== (q.size() == N) || bus.empty !== (q.size() == 0))
                begin errors++; $display("FAIL rnd_occ cyc=%0d got full=%b empty=%b size=%0d", c, bus.full, bus.empty, q.size()); end
            checks++; if (bus.save_column !== 2'(m_tail())) begin errors++; $display("FAIL rnd_tail cyc=%0d got=%0d exp=%0d", c, bus.save_column, m_tail()); end
            checks++; if (bus.restore_checkpoint_success !== m_succ) begin errors++; $display("FAIL rnd_success cyc=%0d got=%b exp=%b", c, bus.restore_checkpoint_success, m_succ); end
            checks++; if (bus.map_restore_valid !== m_mrv) begin errors++; $display("FAIL rnd_map_valid cyc=%0d got=%b exp=%b", c, bus.map_restore_valid, m_mrv); end
            checks++; if (bus.map_restore_table !== m_table) begin errors++; $display("FAIL rnd_table cyc=%0d got=%h exp=%h", c, bus.map_restore_table, m_table); end
            checks++; if (bus.DUT_error !== m_err) begin errors++; $display("FAIL rnd_error cyc=%0d got=%b exp=%b", c, bus.DUT_error, m_err); end
            checks++; if (bus.stat_restores !== exp_restores() || bus.stat_frees !== exp_frees())
                begin errors++; $display("FAIL rnd_stats cyc=%0d got=%0d/%0d exp=%0d/%0d", c, bus.stat_restores, bus.stat_frees, exp_restores(), exp_frees()); end
        end
        nRST = 1'b0;
    endtask

    initial begin
        CLK = 1'b0;
        nRST = 1'b1;
        errors = 0;
        checks = 0;
        set_idle();
        test_reset();
        test_save_restore();
        test_fill_overflow();
        test_in_order_drain();
        test_mispredict_truncate();
        test_mismatch_and_collision();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/checkpoint_table.md
# checkpoint_table

Map-table checkpoint store in the core's dispatch stage; responder on the ROB restore bus. On each branch dispatch it saves a snapshot of the speculative map table into a circular array of columns. On a ROB restore command it validates the column and, on a mispredict, returns the snapshot and discards that column and all younger columns. Columns resolved as correct are freed in order from the head.

## Interface
- CHECKPOINT_COLUMNS, 4: number of columns (power of 2, ≥2).
- ARCH_REGS, 32: map-table entries per snapshot.
- PHYS_TAG_W, 6: physical register tag width.
- ROB_INDEX_W, 4: ROB index width.
- COL_W = $clog2(CHECKPOINT_COLUMNS) (derived).
- CLK in 1: clock; all state updates on posedge.
- nRST in 1: reset, synchronous, active-high (asserted = 1).
- save_valid in 1: dispatch saves a snapshot this cycle.
- save_ROB_index in ROB_INDEX_W: ROB index of the branch.
- save_map_table in ARCH_REGS*PHYS_TAG_W: flattened map table; entry i at [i*PHYS_TAG_W +: PHYS_TAG_W].
- save_ready out 1: a save is accepted this cycle.
- save_column out COL_W: column the save lands in (= tail).
- restore_checkpoint_valid in 1: ROB restore command.
- restore_checkpoint_speculate_failed in 1: 1 = mispredict restore; 0 = branch correct, free column.
- restore_checkpoint_ROB_index in ROB_INDEX_W.
- restore_checkpoint_safe_column in COL_W.
- restore_checkpoint_success out 1: command matched a live column.
- map_restore_valid out 1: map table must load map_restore_table.
- map_restore_table out ARCH_REGS*PHYS_TAG_W.
- full out 1, empty out 1, count out COL_W+1: occupancy.
- DUT_error out 1: protocol violation seen.
- stat_restores out 16, stat_frees out 16: perf counters (see Configuration).

## Operation
- State: per column valid, resolved, ROB index, snapshot. head, tail (COL_W, wrap mod CHECKPOINT_COLUMNS), count.
- save_ready = !full && !restore_checkpoint_valid. Restore always has priority over save.
- Save (save_valid && save_ready): write column[tail]; valid=1, resolved=0; tail+1; count+1.
- save_valid && !save_ready: save dropped, DUT_error=1 next cycle.
- Match: valid[safe_column] && ROB_index[safe_column]==restore_checkpoint_ROB_index && !resolved[safe_column].
- Mismatch: success=0, no state change, no error; the ROB may probe.
- Match, speculate_failed=1: map_restore_table ← snapshot[safe_column]; clear valid/resolved of safe_column and every younger column up to tail-1; tail ← safe_column; count ← (safe_column − head) mod COLUMNS, or 0 if safe_column==head.
- Match, speculate_failed=0: resolved[safe_column]=1; no snapshot output.
- Head drain: each cycle with no mispredict restore, if valid[head] && resolved[head], clear the column, head+1, count−1. At most one column per cycle.
- Drain and save in the same cycle: count is unchanged (−1 +1).
- full = count==COLUMNS; empty = count==0. Wrap: head==tail is disambiguated by count.

## Timing
- Reset: all valid/resolved=0, head=tail=0, count=0, empty=1, full=0, save_ready=1 (combinational), save_column=0, success=0, map_restore_valid=0, map_restore_table=0, DUT_error=0, stat counters=0. Reset asserted mid-operation discards all columns on the next edge.
- Save at edge t: column visible, count updated after t. A restore at t+1 can match it.
- Restore sampled at edge t: restore_checkpoint_success and map_restore_valid are single-cycle pulses registered at t (visible t..t+1). map_restore_table is held until the next mispredict restore.
- A resolved head is freed on the edge after it is marked resolved at the earliest.
- DUT_error is a one-cycle pulse.

## Configuration
- CHECKPOINT_STATS_EN defined: stat_restores counts successful mispredict restores; stat_frees counts columns freed by head drain. Both are 16-bit, saturating at 0xFFFF, and cleared by reset.
- Not defined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Reset, then save ROB idx 3 and map entry 5 = tag 40 → save_column=0, count=1. Restore col0/idx3/failed=1 → success=1, map_restore_valid=1, entry 5 = 40, empty=1.
- Fill 4 saves → full=1, save_ready=0. Fifth save_valid → not stored, DUT_error pulse, count stays 4.
- Saves at cols 0–3, resolve col2 correct → head stays 0. Then resolve col0 and col1 → head drains to 3 over consecutive cycles, count=1.
- Saves at cols 0–3, mispredict on col1 → tail=1, count=1, cols 1–3 invalid. Next save lands in col1.
- Restore with ROB index mismatch on col0 → success=0, state unchanged, no DUT_error. Save and restore in the same cycle → save_ready=0 and the save is dropped.
- Wrap: 6 save/resolve pairs → head=tail=2, empty=1. With CHECKPOINT_STATS_EN defined, stat_frees=6.
